// File: rtl/csr_regfile.sv
// Machine-mode CSR file: ID-stage reads, WB-stage writes, trap entry / mret commit, registered PC redirect.
// Define CSR_COUNTER_EN to build the mcycle (0xB00) and minstret (0xB02) counters.
module csr_regfile #(
    parameter logic [63:0] MTVEC_RESET   = 64'h0,
    parameter logic [63:0] MSTATUS_RESET = 64'h0000_0000_0000_1800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] csr_addr_id,
    output logic [63:0] csr_val_id,
    output logic        csr_illegal_id,
    input  logic        is_csr_wb,
    input  logic [11:0] csr_addr_wb,
    input  logic [63:0] csr_wdata_wb,
    input  logic        inst_retire_wb,
    input  logic        trap_valid_wb,
    input  logic [63:0] trap_cause_wb,
    input  logic [63:0] trap_pc_wb,
    input  logic [63:0] trap_tval_wb,
    input  logic        mret_wb,
    output logic        redirect_valid,
    output logic [63:0] redirect_pc,
    input  logic        redirect_ready
);

    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MIE      = 12'h304;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MTVAL    = 12'h343;
    localparam logic [11:0] ADDR_MIP      = 12'h344;
`ifdef CSR_COUNTER_EN
    localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
`endif

    // MPP[12:11], MPIE[7], MIE[3] are the only bits that exist in mstatus
    localparam logic [63:0] MSTATUS_WMASK = 64'h0000_0000_0000_1888;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [63:0] r_mstatus;
    logic [63:0] r_mie;
    logic [63:0] r_mtvec;
    logic [63:0] r_mscratch;
    logic [63:0] r_mepc;
    logic [63:0] r_mcause;
    logic [63:0] r_mtval;
    logic [63:0] r_redirect_pc;

    logic [63:0] w_mip;
    logic        w_trap;
    logic        w_mret;
    logic        w_wr;
    logic        w_event;
    logic [63:0] w_tvec_base;
    logic [63:0] w_trap_target;
    logic [63:0] w_redirect_tgt;

    function automatic logic [63:0] mstatus_on_trap(input logic [63:0] ms);
        logic [63:0] v;
        v        = ms & MSTATUS_WMASK;
        v[7]     = ms[3];
        v[3]     = 1'b0;
        v[12:11] = 2'b11;
        return v;
    endfunction

    function automatic logic [63:0] mstatus_on_mret(input logic [63:0] ms);
        logic [63:0] v;
        v        = ms & MSTATUS_WMASK;
        v[3]     = ms[7];
        v[7]     = 1'b1;
        v[12:11] = 2'b11;
        return v;
    endfunction

    assign w_mip   = 64'h0;
    assign w_trap  = trap_valid_wb;
    assign w_mret  = mret_wb & ~trap_valid_wb;
    assign w_wr    = is_csr_wb & ~trap_valid_wb & ~mret_wb;
    assign w_event = w_trap | w_mret;

    assign w_tvec_base = {r_mtvec[63:2], 2'b00};

    // Vectored mode only applies to interrupts; exceptions always go to the base
    always_comb begin
        w_trap_target = w_tvec_base;
        if (r_mtvec[1:0] == 2'b01 && trap_cause_wb[63]) begin
            w_trap_target = w_tvec_base + {56'h0, trap_cause_wb[5:0], 2'b00};
        end
    end

    assign w_redirect_tgt = w_trap ? w_trap_target : r_mepc;

`ifdef CSR_COUNTER_EN
    logic [63:0] r_mcycle;
    logic [63:0] r_minstret;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcycle   <= 64'h0;
            r_minstret <= 64'h0;
        end else begin
            if (w_wr && csr_addr_wb == ADDR_MCYCLE) begin
                r_mcycle <= csr_wdata_wb;
            end else begin
                r_mcycle <= r_mcycle + 64'd1;
            end
            if (w_wr && csr_addr_wb == ADDR_MINSTRET) begin
                r_minstret <= csr_wdata_wb;
            end else if (inst_retire_wb) begin
                r_minstret <= r_minstret + 64'd1;
            end
        end
    end
`else
    logic w_unused_retire;
    assign w_unused_retire = inst_retire_wb;
`endif

    always_comb begin
        csr_val_id     = 64'h0;
        csr_illegal_id = 1'b0;
        case (csr_addr_id)
            ADDR_MSTATUS:  csr_val_id = r_mstatus;
            ADDR_MIE:      csr_val_id = r_mie;
            ADDR_MTVEC:    csr_val_id = r_mtvec;
            ADDR_MSCRATCH: csr_val_id = r_mscratch;
            ADDR_MEPC:     csr_val_id = r_mepc;
            ADDR_MCAUSE:   csr_val_id = r_mcause;
            ADDR_MTVAL:    csr_val_id = r_mtval;
            ADDR_MIP:      csr_val_id = w_mip;
`ifdef CSR_COUNTER_EN
            ADDR_MCYCLE:   csr_val_id = r_mcycle;
            ADDR_MINSTRET: csr_val_id = r_minstret;
`endif
            default:       csr_illegal_id = 1'b1;
        endcase
    end

    // Commit: trap beats mret beats a plain CSR write; losers are dropped whole
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mstatus  <= MSTATUS_RESET & MSTATUS_WMASK;
            r_mie      <= 64'h0;
            r_mtvec    <= MTVEC_RESET;
            r_mscratch <= 64'h0;
            r_mepc     <= 64'h0;
            r_mcause   <= 64'h0;
            r_mtval    <= 64'h0;
        end else if (w_trap) begin
            r_mepc    <= {trap_pc_wb[63:2], 2'b00};
            r_mcause  <= trap_cause_wb;
            r_mtval   <= trap_tval_wb;
            r_mstatus <= mstatus_on_trap(r_mstatus);
        end else if (w_mret) begin
            r_mstatus <= mstatus_on_mret(r_mstatus);
        end else if (w_wr) begin
            case (csr_addr_wb)
                ADDR_MSTATUS:  r_mstatus  <= csr_wdata_wb & MSTATUS_WMASK;
                ADDR_MIE:      r_mie      <= csr_wdata_wb;
                ADDR_MTVEC:    r_mtvec    <= csr_wdata_wb;
                ADDR_MSCRATCH: r_mscratch <= csr_wdata_wb;
                ADDR_MEPC:     r_mepc     <= {csr_wdata_wb[63:2], 2'b00};
                ADDR_MCAUSE:   r_mcause   <= csr_wdata_wb;
                ADDR_MTVAL:    r_mtval    <= csr_wdata_wb;
                default:       ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_redirect_pc <= 64'h0;
        end else begin
            r_state <= w_state_nxt;
            if (w_event) begin
                r_redirect_pc <= w_redirect_tgt;
            end
        end
    end

    // A new trap/mret while pending re-targets the redirect even if fetch is accepting
    always_comb begin
        w_state_nxt    = r_state;
        redirect_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_event) begin
                    w_state_nxt = ST_PEND;
                end
            end
            ST_PEND: begin
                redirect_valid = 1'b1;
                if (!w_event && redirect_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign redirect_pc = r_redirect_pc;

endmodule

// File: tb/tb_csr_regfile.sv
// Directed plus randomized bench for csr_regfile against a behavioural CSR model.
module tb_csr_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] csr_addr_id;
    logic [63:0] csr_val_id;
    logic        csr_illegal_id;
    logic        is_csr_wb;
    logic [11:0] csr_addr_wb;
    logic [63:0] csr_wdata_wb;
    logic        inst_retire_wb;
    logic        trap_valid_wb;
    logic [63:0] trap_cause_wb;
    logic [63:0] trap_pc_wb;
    logic [63:0] trap_tval_wb;
    logic        mret_wb;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        redirect_ready;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference state
    logic [63:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
    logic [63:0] m_mcycle, m_minstret, m_rpc;
    logic        m_rv;

    logic [11:0] addr_tbl [12] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                   12'h343, 12'h344, 12'hB00, 12'hB02, 12'h7C0, 12'h301};

    csr_regfile dut (
        .clk            (clk),
        .rst            (rst),
        .csr_addr_id    (csr_addr_id),
        .csr_val_id     (csr_val_id),
        .csr_illegal_id (csr_illegal_id),
        .is_csr_wb      (is_csr_wb),
        .csr_addr_wb    (csr_addr_wb),
        .csr_wdata_wb   (csr_wdata_wb),
        .inst_retire_wb (inst_retire_wb),
        .trap_valid_wb  (trap_valid_wb),
        .trap_cause_wb  (trap_cause_wb),
        .trap_pc_wb     (trap_pc_wb),
        .trap_tval_wb   (trap_tval_wb),
        .mret_wb        (mret_wb),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_ready (redirect_ready)
    );

    always #5 clk = ~clk;

    function automatic bit counters_on();
`ifdef CSR_COUNTER_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit model_ill(input logic [11:0] a);
        case (a)
            12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344: return 1'b0;
            12'hB00, 12'hB02: return !counters_on();
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [63:0] model_read(input logic [11:0] a);
        case (a)
            12'h300: return m_mstatus;
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            12'hB00: return counters_on() ? m_mcycle : 64'h0;
            12'hB02: return counters_on() ? m_minstret : 64'h0;
            default: return 64'h0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_read(input logic [11:0] a);
        csr_addr_id = a;
        #1;
        check($sformatf("rd_val_%h", a), csr_val_id, model_read(a));
        check($sformatf("rd_ill_%h", a), {63'h0, csr_illegal_id}, {63'h0, model_ill(a)});
    endtask

    task automatic check_redirect();
        check("redir_valid", {63'h0, redirect_valid}, {63'h0, m_rv});
        check("redir_pc", redirect_pc, m_rpc);
    endtask

    task automatic clear_inputs();
        rst = 0; is_csr_wb = 0; csr_addr_wb = 0; csr_wdata_wb = 0; inst_retire_wb = 0;
        trap_valid_wb = 0; trap_cause_wb = 0; trap_pc_wb = 0; trap_tval_wb = 0;
        mret_wb = 0; redirect_ready = 0;
    endtask

    // Advance the model by one clock using the current inputs, then let the DUT take the edge.
    task automatic tick();
        logic [63:0] tgt;
        bit wr_ok, wr_cyc, wr_ret;
        wr_ok  = is_csr_wb && !trap_valid_wb && !mret_wb;
        wr_cyc = wr_ok && csr_addr_wb == 12'hB00;
        wr_ret = wr_ok && csr_addr_wb == 12'hB02;
        if (rst) begin
            m_mstatus = 64'h1800; m_mie = 0; m_mtvec = 64'h0; m_mscratch = 0;
            m_mepc = 0; m_mcause = 0; m_mtval = 0; m_mcycle = 0; m_minstret = 0;
            m_rv = 0; m_rpc = 0;
        end else begin
            if (trap_valid_wb) begin
                tgt = m_mtvec & ~64'h3;
                if (m_mtvec[1:0] == 2'b01 && trap_cause_wb[63])
                    tgt = tgt + 64'(trap_cause_wb[5:0]) * 4;
                m_mepc    = trap_pc_wb & ~64'h3;
                m_mcause  = trap_cause_wb;
                m_mtval   = trap_tval_wb;
                m_mstatus = 64'h1800 | (m_mstatus[3] ? 64'h80 : 64'h0);
                m_rv = 1; m_rpc = tgt;
            end else if (mret_wb) begin
                m_rpc     = m_mepc;
                m_mstatus = 64'h1880 | (m_mstatus[7] ? 64'h8 : 64'h0);
                m_rv = 1;
            end else begin
                if (is_csr_wb) begin
                    case (csr_addr_wb)
                        12'h300: m_mstatus  = csr_wdata_wb & 64'h1888;
                        12'h304: m_mie      = csr_wdata_wb;
                        12'h305: m_mtvec    = csr_wdata_wb;
                        12'h340: m_mscratch = csr_wdata_wb;
                        12'h341: m_mepc     = csr_wdata_wb & ~64'h3;
                        12'h342: m_mcause   = csr_wdata_wb;
                        12'h343: m_mtval    = csr_wdata_wb;
                        default: ;
                    endcase
                end
                if (m_rv && redirect_ready) m_rv = 0;
            end
            m_mcycle = wr_cyc ? csr_wdata_wb : m_mcycle + 1;
            if (wr_ret) m_minstret = csr_wdata_wb;
            else if (inst_retire_wb) m_minstret = m_minstret + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [11:0] a, input logic [63:0] d);
        is_csr_wb = 1; csr_addr_wb = a; csr_wdata_wb = d;
        tick();
        is_csr_wb = 0;
    endtask

    initial begin
        clear_inputs();
        csr_addr_id = 0;
        rst = 1;
        tick();
        tick();
        rst = 0;

        // Reset state
        csr_addr_id = 12'h305; #1; check("rst_mtvec", csr_val_id, 64'h0);
        csr_addr_id = 12'h300; #1; check("rst_mstatus", csr_val_id, 64'h1800);
        csr_addr_id = 12'h7C0; #1;
        check("rst_unimpl_val", csr_val_id, 64'h0);
        check("rst_unimpl_ill", {63'h0, csr_illegal_id}, 64'h1);
        check("rst_rv", {63'h0, redirect_valid}, 64'h0);
        check("rst_rpc", redirect_pc, 64'h0);

        // Write visible one cycle later; mepc low bits cleared
        is_csr_wb = 1; csr_addr_wb = 12'h340; csr_wdata_wb = 64'hDEAD_BEEF;
        csr_addr_id = 12'h340; #1; check("mscratch_old", csr_val_id, 64'h0);
        tick();
        is_csr_wb = 0;
        csr_addr_id = 12'h340; #1; check("mscratch_new", csr_val_id, 64'hDEAD_BEEF);
        wb_write(12'h341, 64'h1003);
        csr_addr_id = 12'h341; #1; check("mepc_align", csr_val_id, 64'h1000);
        wb_write(12'h344, 64'h55);
        check_read(12'h344);

        // Vectored interrupt trap, then hold the redirect
        wb_write(12'h305, 64'h8000_0001);
        wb_write(12'h300, 64'h8);
        trap_valid_wb = 1; trap_cause_wb = 64'h8000_0000_0000_0007;
        trap_pc_wb = 64'h2004; trap_tval_wb = 64'h77;
        tick();
        clear_inputs();
        check("trap_rv", {63'h0, redirect_valid}, 64'h1);
        check("trap_rpc", redirect_pc, 64'h8000_001C);
        csr_addr_id = 12'h341; #1; check("trap_mepc", csr_val_id, 64'h2004);
        csr_addr_id = 12'h300; #1; check("trap_mstatus", csr_val_id, 64'h1880);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_rpc", redirect_pc, 64'h8000_001C);
            check("hold_rv", {63'h0, redirect_valid}, 64'h1);
        end
        redirect_ready = 1;
        tick();
        redirect_ready = 0;
        check("accept_rv", {63'h0, redirect_valid}, 64'h0);

        // Trap, mret and CSR write together: only the trap lands
        trap_valid_wb = 1; trap_cause_wb = 64'h2; trap_pc_wb = 64'h3000;
        mret_wb = 1; is_csr_wb = 1; csr_addr_wb = 12'h340; csr_wdata_wb = 64'h1234;
        tick();
        clear_inputs();
        check("prio_rpc", redirect_pc, 64'h8000_0000);
        csr_addr_id = 12'h340; #1; check("prio_mscratch", csr_val_id, 64'hDEAD_BEEF);
        check_read(12'h341);
        check_read(12'h300);

        // mret while pending and ready: stays pending with the new target
        mret_wb = 1; redirect_ready = 1;
        tick();
        clear_inputs();
        check("mret_rv", {63'h0, redirect_valid}, 64'h1);
        check("mret_rpc", redirect_pc, 64'h3000);
        check_read(12'h300);
        rst = 1;
        tick();
        rst = 0;
        check("rst_pend_rv", {63'h0, redirect_valid}, 64'h0);
        check_redirect();

        // Counters
        check_read(12'hB00);
        check_read(12'hB02);
`ifdef CSR_COUNTER_EN
        wb_write(12'hB02, 64'hFFFF_FFFF_FFFF_FFFF);
        inst_retire_wb = 1;
        tick();
        inst_retire_wb = 0;
        csr_addr_id = 12'hB02; #1; check("minstret_wrap", csr_val_id, 64'h0);
        wb_write(12'hB00, 64'h10);
        csr_addr_id = 12'hB00; #1; check("mcycle_wr", csr_val_id, 64'h10);
        tick();
        csr_addr_id = 12'hB00; #1; check("mcycle_inc", csr_val_id, 64'h11);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            rst            = ($urandom_range(0, 39) == 0);
            trap_valid_wb  = ($urandom_range(0, 7) == 0);
            mret_wb        = ($urandom_range(0, 7) == 0);
            is_csr_wb      = ($urandom_range(0, 2) == 0);
            csr_addr_wb    = addr_tbl[$urandom_range(0, 11)];
            csr_wdata_wb   = {$urandom, $urandom};
            trap_cause_wb  = {$urandom, $urandom};
            trap_pc_wb     = {$urandom, $urandom};
            trap_tval_wb   = {$urandom, $urandom};
            redirect_ready = $urandom_range(0, 1) == 1;
            inst_retire_wb = $urandom_range(0, 1) == 1;
            tick();
            check_redirect();
            check_read(addr_tbl[$urandom_range(0, 11)]);
        end
        clear_inputs();
        tick();
        check_redirect();
        for (int k = 0; k < 12; k++) check_read(addr_tbl[k]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/csr_regfile.md
Name: csr_regfile

Overview:
- Machine-mode CSR storage and the write/commit end of the CSR path.
- ID-stage CSR reads are served from here; the ID-stage forwarding unit overrides these reads with EXE/MEM/WB values.
- WB-stage CSR writes, trap entry and mret commit here.
- Emits a registered PC redirect, held until fetch accepts it.

Parameters:
- MTVEC_RESET, 64'h0, reset value of mtvec.
- MSTATUS_RESET, 64'h0000_0000_0000_1800, reset value of mstatus (MPP=2'b11, MIE=0, MPIE=0).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- csr_addr_id  in  12  ID-stage read address
- csr_val_id  out  64  combinational read data for csr_addr_id, from registered state only; no internal WB bypass
- csr_illegal_id  out  1  csr_addr_id is not an implemented CSR
- is_csr_wb  in  1  WB-stage CSR write strobe
- csr_addr_wb  in  12  WB write address
- csr_wdata_wb  in  64  final value to write (op already resolved upstream)
- inst_retire_wb  in  1  one instruction retires this cycle
- trap_valid_wb  in  1  trap commits this cycle
- trap_cause_wb  in  64  mcause value (bit63 = interrupt)
- trap_pc_wb  in  64  faulting PC
- trap_tval_wb  in  64  mtval value
- mret_wb  in  1  mret commits this cycle
- redirect_valid  out  1  redirect pending
- redirect_pc  out  64  target PC
- redirect_ready  in  1  fetch accepts the redirect

Behaviour:
- Implemented CSRs:
  - mstatus 0x300, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343, mip 0x344.
  - mcycle 0xB00 and minstret 0xB02, under macro only.
- Unimplemented address:
  - csr_val_id=0 and csr_illegal_id=1.
  - A WB write to it is ignored.
- Reset: mtvec=MTVEC_RESET, mstatus=MSTATUS_RESET, all other CSRs 0, redirect_valid=0, redirect_pc=0.
- mepc write: bits [1:0] forced to 0.
- mip: read-only here; writes are ignored.
- mstatus: only bits 3 (MIE), 7 (MPIE) and 12:11 (MPP) are writable; all other bits read 0.
- Commit priority within one cycle: trap_valid_wb > mret_wb > is_csr_wb. A lower-priority event is dropped entirely.
- Trap commit:
  - mepc<=trap_pc_wb & ~3; mcause<=trap_cause_wb; mtval<=trap_tval_wb.
  - MPIE<=MIE; MIE<=0; MPP<=2'b11.
  - Target = {mtvec[63:2],2'b00}.
  - Exception: if mtvec[1:0]==1 and trap_cause_wb[63]==1, target = base + 4*trap_cause_wb[5:0].
- mret commit: MIE<=MPIE; MPIE<=1; MPP<=2'b11; target = mepc, value before this edge.
- Redirect state machine, states IDLE and PEND:
  - IDLE -> PEND on trap or mret: redirect_pc<=target, redirect_valid=1 from the next cycle (latency 1).
  - PEND with redirect_ready=1 and no new event -> IDLE.
  - PEND with a new trap or mret in the same cycle: stay in PEND, redirect_pc overwritten with the new target. This holds regardless of redirect_ready.
  - PEND and redirect_ready=0: hold redirect_pc stable.
- A write at WB is visible on csr_val_id the cycle after the edge.
- rst asserted in any state forces IDLE and the reset values on the next edge, including mid-PEND.

Optional Feature:
- Macro CSR_COUNTER_EN.
- Defined:
  - mcycle increments every cycle after reset.
  - minstret increments when inst_retire_wb=1.
  - Both are 64-bit and wrap from all-ones to 0.
  - A WB write to a counter wins over that cycle's increment: the counter holds csr_wdata_wb after the edge.
- Undefined: 0xB00 and 0xB02 are unimplemented (read 0, illegal=1); no counter registers are generated.

Test Plan:
- Reset, then read 0x305 and 0x300 -> MTVEC_RESET and 64'h1800; read 0x7C0 -> val 0, illegal=1; redirect_valid=0.
- WB write 0x340 = 64'hDEAD_BEEF at cycle N -> csr_val_id reads old value at N and 64'hDEAD_BEEF at N+1; write 0x341 = 64'h1003 -> reads 64'h1000.
- mtvec=64'h8000_0001, MIE=1, trap cause=64'h8000_0000_0000_0007, pc=64'h2004:
  - -> next cycle redirect_valid=1, redirect_pc=64'h8000_001C; mepc=64'h2004; MIE=0, MPIE=1.
  - Hold redirect_ready=0 for 3 cycles -> redirect_pc stable; ready=1 -> valid=0 next cycle.
- Trap and mret in the same cycle with is_csr_wb to 0x340 -> only trap effects; mscratch unchanged; redirect_pc = trap target.
- PEND with mret arriving while ready=1 -> stays valid, redirect_pc = mepc; rst during PEND -> valid=0 next cycle.
- With CSR_COUNTER_EN:
  - minstret=all-ones plus retire -> 0.
  - WB write mcycle=64'h10 -> reads 64'h10 then 64'h11.
